test_memory_model: RTL



---
 rtl/test_memory_model_pkg.sv | 37 +++
 rtl/test_memory_model_if.sv | 28 ++
 rtl/test_memory_model_lfsr.sv | 25 ++
 rtl/test_memory_model.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/test_memory_model_pkg.sv
// Shared types and helpers for the backing-store model: FSM states, byte/index math, byte-enable merge.
package test_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

  localparam int DEF_DATA_W = 32;
  localparam int BYTES      = DEF_DATA_W / 8;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Byte address to word index; the mask makes out-of-range addresses alias.
  function automatic logic [31:0] word_index(input logic [63:0] addr, input int nbytes,
                                             input int depth);
    logic [63:0] w;
    w = addr >> log2c(nbytes);
    return 32'(w & 64'(depth - 1));
  endfunction

  function automatic logic [MAX_DATA_W-1:0] be_merge(input logic [MAX_DATA_W-1:0] old_w,
                                                     input logic [MAX_DATA_W-1:0] new_w,
                                                     input logic [MAX_BYTES-1:0]  be);
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/test_memory_model_if.sv
// Request/response bundle between a cache miss path (master) and the memory model (slave).
interface test_memory_model_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BYTES_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wr;
  logic [DATA_W-1:0] req_wdata;
  logic [BYTES_W-1:0] req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_wr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_data, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_addr, req_wr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_data, rsp_last, busy
  );
endinterface

// File: rtl/test_memory_model_lfsr.sv
// Stall generator: 16-bit Fibonacci LFSR (taps 16,14,13,11); never stalls more than 4 cycles in a row.
module test_mem_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  output logic o_stall
);
  logic [15:0] r_lfsr;
  logic [2:0]  r_run;

  assign o_stall = i_active && r_lfsr[0] && (r_run != 3'd4);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
      r_run  <= 3'd0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (i_active && o_stall) r_run <= r_run + 3'd1;
      else                     r_run <= 3'd0;
    end
  end
endmodule

// File: rtl/test_memory_model.sv
// Behavioural backing store with latency and burst reads; TEST_MEM_STALL_EN adds random beat stalls.
// Unwritten words read back as their byte address via a per-word written flag cleared on reset.
module test_memory_model
  import test_mem_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 3,
  parameter int          BURST_LEN = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                clk,
  input logic                reset,
  test_memory_model_if.slave bus
);
  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? log2c(DEPTH) : 1;
  localparam int BEAT_W = log2c(BURST_LEN) + 1;
  localparam int CNT_W  = log2c(LATENCY + 2);

  state_t             r_state, w_state_n;
  logic [IDX_W-1:0]   r_idx, w_idx_n, w_req_idx, w_rd_idx;
  logic [BEAT_W-1:0]  r_beat, w_beat_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic               r_rsp_vld, w_rsp_vld_n, r_rsp_last, w_rsp_last_n;
  logic [DATA_W-1:0]  r_rsp_dat, w_rsp_dat_n, w_rd_word;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]   r_wvld;
  logic               w_accept, w_stall;

  assign w_req_idx = IDX_W'(word_index(64'(bus.req_addr), NBYTES, DEPTH));
  assign w_rd_idx  = (r_state == IDLE) ? w_req_idx : r_idx + IDX_W'(r_beat);
  assign w_rd_word = r_wvld[w_rd_idx] ? r_mem[w_rd_idx] : DATA_W'(32'(w_rd_idx) * NBYTES);
  assign w_accept  = bus.req_valid && (r_state == IDLE);

`ifdef TEST_MEM_STALL_EN
  logic w_stall_win;
  assign w_stall_win = (r_state == BURST) && !(r_rsp_vld && r_rsp_last);
  test_mem_lfsr #(.SEED(LFSR_SEED)) u_stall (
    .clk     (clk),
    .reset   (reset),
    .i_active(w_stall_win),
    .o_stall (w_stall)
  );
`else
  localparam logic [15:0] LFSR_SEED_UNUSED = LFSR_SEED;
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_beat_n     = r_beat;
    w_cnt_n      = r_cnt;
    w_rsp_vld_n  = 1'b0;
    w_rsp_last_n = 1'b0;
    w_rsp_dat_n  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.req_wr) begin
            w_state_n    = WACK;
            w_rsp_vld_n  = 1'b1;
            w_rsp_last_n = 1'b1;
          end else begin
            w_idx_n  = w_req_idx;
            w_beat_n = '0;
            if (LATENCY == 0) begin
              w_state_n    = BURST;
              w_rsp_vld_n  = 1'b1;
              w_rsp_dat_n  = w_rd_word;
              w_rsp_last_n = (BURST_LEN == 1);
              w_beat_n     = BEAT_W'(1);
            end else begin
              w_state_n = WAIT;
              w_cnt_n   = CNT_W'(LATENCY);
            end
          end
        end
      end
      // The first beat is registered on the edge that ends the last wait cycle.
      WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_n    = BURST;
          w_rsp_vld_n  = 1'b1;
          w_rsp_dat_n  = w_rd_word;
          w_rsp_last_n = (BURST_LEN == 1);
          w_beat_n     = BEAT_W'(1);
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      BURST: begin
        if (r_rsp_vld && r_rsp_last) begin
          w_state_n = IDLE;
          w_beat_n  = '0;
        end else if (!w_stall) begin
          w_rsp_vld_n  = 1'b1;
          w_rsp_dat_n  = w_rd_word;
          w_rsp_last_n = (r_beat == BEAT_W'(BURST_LEN - 1));
          w_beat_n     = r_beat + BEAT_W'(1);
        end
      end
      WACK:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_beat     <= '0;
      r_cnt      <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_last <= 1'b0;
      r_rsp_dat  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_beat     <= w_beat_n;
      r_cnt      <= w_cnt_n;
      r_rsp_vld  <= w_rsp_vld_n;
      r_rsp_last <= w_rsp_last_n;
      r_rsp_dat  <= w_rsp_dat_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wvld <= '0;
    end else if (w_accept && bus.req_wr) begin
      r_mem[w_req_idx]  <= DATA_W'(be_merge(MAX_DATA_W'(w_rd_word), MAX_DATA_W'(bus.req_wdata),
                                            MAX_BYTES'(bus.req_be)));
      r_wvld[w_req_idx] <= 1'b1;
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.rsp_data  = r_rsp_dat;
endmodule
